// File: rtl/add64_pkg.sv
// Shared definitions for the slice-serial 64-bit adder: controller states and
// default geometry.
package add64_pkg;

  localparam int SLICE_W_DEF = 16;
  localparam int N_SLICE_DEF = 4;
  localparam int IDX_W       = (N_SLICE_DEF > 1) ? $clog2(N_SLICE_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for an arbitrary slice count (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add16_slice.sv
// Combinational SLICE_W-bit adder slice; also reports the carry into its MSB
// so the caller can derive signed overflow on the top slice.
module add16_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         c_msb_in_o
);

  logic [W:0] full;

  always_comb begin
    full       = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
    s_o        = full[W-1:0];
    co_o       = full[W];
    // carry into bit W-1 recovered from that bit's sum: s = a ^ b ^ c
    c_msb_in_o = a_i[W-1] ^ b_i[W-1] ^ full[W-1];
  end

endmodule

// File: rtl/add64_seq.sv
// Slice-serial adder/subtractor: one SLICE_W-bit slice per cycle through a
// single shared add16_slice, carry held in a register between slices.
module add64_seq
  import add64_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int N_SLICE = N_SLICE_DEF,
  localparam int W      = SLICE_W * N_SLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int IW = idx_w(N_SLICE);
  localparam logic [IW-1:0] LAST = IW'(N_SLICE - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cout_q, cout_d, ovf_q, ovf_d;

  logic [SLICE_W-1:0] sl_s;
  logic               sl_co, sl_msb;

  add16_slice #(.W(SLICE_W)) u_slice (
    .a_i        (a_q[int'(idx_q)*SLICE_W +: SLICE_W]),
    .b_i        (b_q[int'(idx_q)*SLICE_W +: SLICE_W]),
    .ci_i       (carry_q),
    .s_o        (sl_s),
    .co_o       (sl_co),
    .c_msb_in_o (sl_msb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        // subtraction is a + ~b + 1, so cin is ignored
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = sub | cin;
        idx_d   = '0;
        sum_d   = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = sl_s;
        carry_d = sl_co;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = sl_co;
          ovf_d   = sl_co ^ sl_msb;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_add64_seq.sv
// Randomized scoreboard bench for add64_seq: a cycle-level acceptance model
// queues arithmetic results, a negedge monitor checks each done pulse.
module tb_add64_seq;

  localparam int NS  = 4;
  localparam int LAT = NS;        // accept edge -> done cycle, in edges
  localparam int PER = NS + 2;    // one operation per PER cycles

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [63:0] sum;

  exp_t q[$];
  exp_t last;
  int   cyc = 0, mdl_cnt = 0, dn_cnt = 0;
  int   n_vec = 0, n_err = 0;

  add64_seq dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_op(input logic [63:0] x, input logic [63:0] y,
                                  input logic c, input logic s);
    exp_t        e;
    logic [64:0] r;
    logic [63:0] yy;
    yy   = s ? ~y : y;
    r    = {1'b0, x} + {1'b0, yy} + 65'(s ? 1'b1 : c);
    e.s  = r[63:0];
    e.co = r[64];
    // signed overflow: equal operand signs, different result sign
    e.ov = (x[63] == yy[63]) && (r[63] != x[63]);
    e.due = 0;
    return e;
  endfunction

  // reference protocol model: one accepted start per PER cycles, reset flushes
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      mdl_cnt = 0;
      q.delete();
    end else if (mdl_cnt == 0 && start) begin
      e     = ref_op(a, b, cin, sub);
      e.due = cyc + LAT;
      q.push_back(e);
      mdl_cnt = PER - 1;
    end else if (mdl_cnt > 0) begin
      mdl_cnt--;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    n_vec++;
    if (busy !== (mdl_cnt > 0)) begin
      n_err++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, mdl_cnt > 0);
    end
    if (done === 1'b1) begin
      dn_cnt++;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done cyc=%0d sum=%h", cyc, sum);
      end else begin
        e = q.pop_front();
        last = e;
        if (sum !== e.s || cout !== e.co || ovf !== e.ov || cyc != e.due) begin
          n_err++;
          $display("FAIL result cyc=%0d got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b due=%0d",
                   cyc, sum, cout, ovf, e.s, e.co, e.ov, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((mdl_cnt != 0 || q.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_err++;
      $display("FAIL timeout waiting for idle at cyc=%0d", cyc);
    end
  endtask

  task automatic op(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
    a = x; b = y; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // scramble inputs while in flight; they must not affect the result
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
    wait_idle();
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("reset_out", {sum, cout, ovf}, '0);
    chk("reset_ctl", {64'd0, busy, done}, '0);
    rst = 1'b0;
    @(negedge clk);

    op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    op(64'd5, 64'd7, 1'b1, 1'b1);
    op(64'd7, 64'd5, 1'b0, 1'b1);
    chk("sub_7_5", {sum, cout, ovf}, {64'd2, 1'b1, 1'b0});
    op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold", {sum, cout, ovf}, {last.s, last.co, last.ov});

    // reset on the third RUN cycle, with start also high
    a = 64'h1234; b = 64'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", {sum, cout, ovf}, '0);
    chk("rst_mid_ctl", {64'd0, busy, done}, '0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    op(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);

    // start held for 20 cycles with operands changing every cycle
    d0 = dn_cnt;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_dones", 66'(dn_cnt - d0), 66'd3);
    wait_idle();

    // random traffic, including starts issued while busy
    for (int i = 0; i < 300; i++) begin
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       begin a = '1; b = {$urandom, $urandom}; end
        1:       begin a = {1'b0, {63{1'b1}}}; b = 64'($urandom_range(0, 3)); end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      endcase
      cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    chk("drain", 66'(q.size()), 66'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add64_seq.md
ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 Parameter: SLICE_W, default 16, width of one adder slice.
REQ-002 Parameter: N_SLICE, default 4, slices per operand; operand width W = SLICE_W*N_SLICE (64).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 sub  input  1  0 = a+b+cin; 1 = a-b (b inverted, cin ignored, carry-in forced 1).
REQ-007 a  input  W  operand A; sampled with start.
REQ-008 b  input  W  operand B; sampled with start.
REQ-009 cin  input  1  carry-in for add; sampled with start.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 sum  output  W  result, held until next accepted start.
REQ-013 cout  output  1  carry out of MSB slice.
REQ-014 ovf  output  1  signed overflow: carry into MSB xor cout.

Function
REQ-015 States SHALL be IDLE, RUN, DONE; encoding in shared package.
REQ-016 IDLE with start=1 at edge N SHALL latch a, b (inverted if sub), carry = sub ? 1 : cin, slice index = 0, clear sum, enter RUN.
REQ-017 Each RUN cycle SHALL add slice[idx] of latched a, b and carry register, write sum slice idx, store slice carry-out in carry register, increment idx.
REQ-018 RUN with idx = N_SLICE-1 SHALL, at that edge, write final slice, cout, ovf, and enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: start at edge N -> done=1 during cycle after edge N+N_SLICE (5 cycles for default); sum/cout/ovf valid from that cycle until next accepted start.
REQ-021 start during RUN or DONE SHALL be ignored (no queuing); start in the DONE->IDLE cycle boundary is taken only when state is IDLE.
REQ-022 Back-to-back: start held high continuously SHALL yield one operation every N_SLICE+2 cycles.
REQ-023 Arithmetic SHALL be modulo 2^W; cout is the true carry (for sub, cout=1 means no borrow).
REQ-024 Changes on a, b, cin, sub after acceptance SHALL NOT affect the in-flight result.
REQ-025 Partial sum slices SHALL be visible on sum during RUN; consumers use only the done cycle or later.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, done=0, busy=0, regardless of state.
REQ-027 Reset mid-RUN SHALL abandon the operation with no done pulse; rst has priority over start in the same cycle.

Structure
REQ-028 Shared package add64_pkg SHALL hold state enum (IDLE, RUN, DONE), SLICE_W/N_SLICE defaults and index width constant.
REQ-029 One sub-module add16_slice SHALL implement the combinational SLICE_W-bit add (a, b, ci -> s, co, c_msb_in); instantiated once, time-multiplexed.
REQ-030 Controller and datapath registers SHALL reside in add64_seq; no latches, no combinational loop through the slice.

Verification
REQ-031 a=0x0000_0000_0000_FFFF, b=1, cin=0, sub=0 -> done 5 cycles after start, sum=0x0000_0000_0001_0000, cout=0, ovf=0.
REQ-032 a=b=0xFFFF_FFFF_FFFF_FFFF, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=1, ovf=0.
REQ-033 a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-034 sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; sub=1, a=7, b=5 -> sum=2, cout=1.
REQ-035 rst pulsed at 3rd RUN cycle -> no done pulse, all outputs 0 next cycle; new start then completes normally.
REQ-036 start held high 20 cycles, operands changed every cycle -> exactly 3 done pulses, each matching operands sampled at its accepting edge.
